// File: rtl/master_bus_if_pkg.sv
// Shared types and constants for the master-side serial link engine.
package bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        ID,
        WAIT_RESP,
        COM,
        SPLIT,
        END0,
        END1,
        NAKD,
        BACKOFF
    } mbi_state_t;

    localparam logic [2:0] PAT_ACK      = 3'b101;
    localparam logic [2:0] PAT_NAK      = 3'b110;
    localparam logic [2:0] PAT_SPL      = 3'b010;
    localparam int         PREAMBLE_LEN = 3;

endpackage

// File: rtl/master_bus_if_if.sv
// Core-side request signals and serial line pair of the master link engine.
interface mbi_if #(
    parameter int S_ID_WIDTH = 2
);
    logic                  req;
    logic [S_ID_WIDTH-1:0] slave_id;
    logic                  core_done;
    logic                  bus_tx;
    logic                  bus_rx;
    logic                  granted;
    logic                  split;
    logic                  nak_o;
    logic                  busy;

    modport master (
        input  req, slave_id, core_done, bus_rx,
        output bus_tx, granted, split, nak_o, busy
    );

    modport slave (
        output req, slave_id, core_done, bus_rx,
        input  bus_tx, granted, split, nak_o, busy
    );

endinterface

// File: rtl/master_bus_if_rx_pattern_det.sv
// Response detector: two stored bits plus the live bit form the 3-bit window (newest in LSB).
module rx_pattern_det
    import bus_pkg::*;
(
    input  logic clk,
    input  logic rstN,
    input  logic i_clr,
    input  logic i_bit,
    output logic o_ack,
    output logic o_nak,
    output logic o_spl
);
    logic [1:0] r_hist;
    logic [2:0] w_window;

    // Matching on the live bit lets the FSM react on the edge the last pattern bit arrives.
    assign w_window = {r_hist, i_bit};

    always_ff @(posedge clk) begin
        if (!rstN || i_clr) begin
            r_hist <= '0;
        end else begin
            r_hist <= w_window[1:0];
        end
    end

    assign o_ack = (w_window == PAT_ACK);
    assign o_nak = (w_window == PAT_NAK);
    assign o_spl = (w_window == PAT_SPL);

endmodule

// File: rtl/master_bus_if.sv
// Master-side serial link engine: request frame, ack/nak/split tracking, end frame.
// Define MASTER_BUS_IF_RETRY_EN to retry refused requests after a growing backoff.
module master_bus_if
    import bus_pkg::*;
#(
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int TIMEOUT    = 16,
    parameter int MAX_RETRY  = 3
) (
    input logic   clk,
    input logic   rstN,
    mbi_if.master bus
);
    localparam int BACKOFF_MAX = 4 * (MAX_RETRY + 1);
    localparam int CNT_MAX     = (TIMEOUT > BACKOFF_MAX) ? TIMEOUT : BACKOFF_MAX;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    mbi_state_t            r_state, w_nextState;
    logic [CNT_W-1:0]      r_cnt, w_cntNext;
    logic [S_ID_WIDTH-1:0] r_id, w_idShifted;
    logic                  r_busTx, r_granted, r_split, r_nak, r_busy;
    logic                  w_txNext, w_nakNext, w_latchId, w_clrRx;
    logic                  w_rxAck, w_rxNak, w_rxSpl;
`ifdef MASTER_BUS_IF_RETRY_EN
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0]      r_retry;
    logic                  w_retryInc, w_retryClr;
`endif

    rx_pattern_det u_rxDet (
        .clk   (clk),
        .rstN  (rstN),
        .i_clr (w_clrRx),
        .i_bit (bus.bus_rx),
        .o_ack (w_rxAck),
        .o_nak (w_rxNak),
        .o_spl (w_rxSpl)
    );

    always_comb begin
        w_nextState = r_state;
        w_latchId   = 1'b0;
        w_nakNext   = 1'b0;
`ifdef MASTER_BUS_IF_RETRY_EN
        w_retryInc  = 1'b0;
        w_retryClr  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (bus.slave_id != '0) begin
                        w_nextState = PRE;
                        w_latchId   = 1'b1;
                    end else begin
                        w_nakNext = 1'b1;
                    end
                end
            end
            PRE:  if (r_cnt == CNT_W'(PREAMBLE_LEN - 1)) w_nextState = ID;
            ID:   if (r_cnt == CNT_W'(S_ID_WIDTH - 1)) w_nextState = WAIT_RESP;
            WAIT_RESP: begin
                // ACK is checked first so it beats a timeout landing on the same cycle.
                if (w_rxAck) begin
                    w_nextState = COM;
`ifdef MASTER_BUS_IF_RETRY_EN
                    w_retryClr  = 1'b1;
`endif
                end else if (w_rxNak || r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_nextState = NAKD;
`ifdef MASTER_BUS_IF_RETRY_EN
                    w_nakNext   = (r_retry == RTY_W'(MAX_RETRY));
`else
                    w_nakNext   = 1'b1;
`endif
                end
            end
            COM: begin
                if (bus.core_done)  w_nextState = END0;
                else if (w_rxSpl)   w_nextState = SPLIT;
            end
            SPLIT: if (w_rxAck) w_nextState = COM;
            END0:  w_nextState = END1;
            END1:  w_nextState = IDLE;
`ifdef MASTER_BUS_IF_RETRY_EN
            NAKD:  w_nextState = (r_retry == RTY_W'(MAX_RETRY)) ? IDLE : BACKOFF;
            BACKOFF: begin
                if (r_cnt == CNT_W'({r_retry, 2'b11})) begin
                    w_nextState = PRE;
                    w_retryInc  = 1'b1;
                end
            end
`else
            NAKD:  w_nextState = IDLE;
`endif
            default: w_nextState = IDLE;
        endcase

        w_cntNext   = (w_nextState != r_state) ? '0 : r_cnt + CNT_W'(1);
        w_idShifted = r_id << w_cntNext;
        w_clrRx     = (w_nextState == WAIT_RESP) && (r_state != WAIT_RESP);

        w_txNext = 1'b0;
        case (w_nextState)
            PRE, COM, END1: w_txNext = 1'b1;
            ID:             w_txNext = w_idShifted[S_ID_WIDTH-1];
            default:        w_txNext = 1'b0;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_id      <= '0;
            r_busTx   <= 1'b0;
            r_granted <= 1'b0;
            r_split   <= 1'b0;
            r_nak     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_cntNext;
            if (w_latchId) r_id <= bus.slave_id;
            r_busTx   <= w_txNext;
            r_granted <= (w_nextState == COM);
            r_split   <= (w_nextState == SPLIT);
            r_nak     <= w_nakNext;
            r_busy    <= (w_nextState != IDLE);
        end
    end

`ifdef MASTER_BUS_IF_RETRY_EN
    always_ff @(posedge clk) begin
        if (!rstN || r_state == IDLE || w_retryClr) begin
            r_retry <= '0;
        end else if (w_retryInc) begin
            r_retry <= r_retry + RTY_W'(1);
        end
    end
`endif

    assign bus.bus_tx  = r_busTx;
    assign bus.granted = r_granted;
    assign bus.split   = r_split;
    assign bus.nak_o   = r_nak;
    assign bus.busy    = r_busy;

endmodule
